// File: rtl/dmem_pkg.sv
// Shared types, funct3 codes and the CPU access legality rule for the data-memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DBG = 1'b1
  } req_src_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Unsigned variants only exist for loads; halfwords need even, words need 4-byte alignment.
  function automatic logic cpu_access_ok(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~addr_lo[0];
      F3_LW:   ok = (addr_lo == 2'b00);
      F3_LBU:  ok = ~is_store;
      F3_LHU:  ok = ~is_store & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/replication and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_raw_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_rep_o,
  output logic [DATA_W-1:0] rdata_ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o        = 4'b1111;
    wdata_rep_o = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_rep_o = {(DATA_W/8){wdata_i[7:0]}};
      end
      2'b01: begin
        be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_rep_o = {(DATA_W/16){wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = rdata_raw_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_raw_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_LB:   rdata_ext_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  rdata_ext_o = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_LH:   rdata_ext_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_LHU:  rdata_ext_o = {{(DATA_W-16){1'b0}}, half_sel};
      default: rdata_ext_o = rdata_raw_i;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory sequencer shared by the MEM stage and a word-wide debug/loader port.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS    = 9,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [2:0]            cpu_funct3,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic [31:0]           mem_raddr,
  output logic [31:0]           mem_waddr,
  output logic [DATA_W-1:0]     mem_datain,
  output logic [3:0]            mem_wr,
  input  logic [DATA_W-1:0]     mem_dataout
);

  localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int BURST_W = $clog2(MAX_CPU_BURST + 1);
  localparam logic [LAT_W-1:0]   LAT_LOAD  = LAT_W'(RD_LAT - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_CPU_BURST);

  state_t                state_q, state_d;
  req_src_t              src_q, src_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic                  err_q, err_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     cpu_rdata_q, dbg_rdata_q;
  logic                  cpu_win, dbg_win, cpu_ok;
  logic [3:0]            be;
  logic [DATA_W-1:0]     wdata_rep, rdata_ext;
  logic [31:0]           word_addr;

  // Grants are suppressed while reset is asserted so every output reads 0 during reset.
  always_comb begin
    cpu_ok  = cpu_access_ok(cpu_we, cpu_funct3, cpu_addr[1:0]);
    cpu_win = reset_n && (state_q == IDLE) && cpu_req && (!dbg_req || (burst_q < BURST_MAX));
    dbg_win = reset_n && (state_q == IDLE) && dbg_req && !cpu_win;
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    lat_d   = lat_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_win) begin
          addr_d  = cpu_addr;
          f3_d    = cpu_funct3;
          wdata_d = cpu_wdata;
          src_d   = SRC_CPU;
          lat_d   = LAT_LOAD;
          if (!cpu_ok) err_d = 1'b1;
          else         state_d = cpu_we ? WRITE : READ;
        end else if (dbg_win) begin
          addr_d  = dbg_addr & ~DM_ADDRESS'(3);
          f3_d    = F3_LW;
          wdata_d = dbg_wdata;
          src_d   = SRC_DBG;
          lat_d   = LAT_LOAD;
          state_d = dbg_we ? WRITE : READ;
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (lat_q == '0) state_d = RESP;
        else             lat_d   = lat_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Starvation guard: count CPU wins only while debug is actually waiting.
    burst_d = burst_q;
    if (!dbg_req || dbg_win)                     burst_d = '0;
    else if (cpu_win && (burst_q < BURST_MAX))   burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_CPU;
      lat_q       <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      lat_q   <= lat_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      if (cpu_rvalid) cpu_rdata_q <= rdata_ext;
      if (dbg_rvalid) dbg_rdata_q <= rdata_ext;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    f3_q    <= f3_d;
    wdata_q <= wdata_d;
  end

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .funct3_i    (f3_q),
    .addr_lo_i   (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .rdata_raw_i (mem_dataout),
    .be_o        (be),
    .wdata_rep_o (wdata_rep),
    .rdata_ext_o (rdata_ext)
  );

  assign word_addr  = 32'({addr_q[DM_ADDRESS-1:2], 2'b00});
  assign cpu_gnt    = cpu_win;
  assign dbg_gnt    = dbg_win;
  assign cpu_stall  = reset_n & cpu_req & ~cpu_win;
  assign cpu_err    = err_q;
  assign cpu_rvalid = (state_q == RESP) && (src_q == SRC_CPU);
  assign dbg_rvalid = (state_q == RESP) && (src_q == SRC_DBG);
  // Load data passes straight through in RESP and is held afterwards.
  assign cpu_rdata  = cpu_rvalid ? rdata_ext : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? rdata_ext : dbg_rdata_q;
  assign mem_wr     = (state_q == WRITE) ? be        : 4'b0000;
  assign mem_waddr  = (state_q == WRITE) ? word_addr : '0;
  assign mem_datain = (state_q == WRITE) ? wdata_rep : '0;
  assign mem_raddr  = (state_q == READ)  ? word_addr : '0;

endmodule
